// File: rtl/fft2d_tile_sched_pkg.sv
// fft2d_tile_sched_pkg: shared complex/tile types, FSM states and default sizing
// for the 4x4 2-D FFT tile scheduler.
package fft2d_tile_sched_pkg;
  localparam int DEF_ADDR_WIDTH = 13;
  typedef struct packed {
    logic signed [15:0] re;
    logic signed [15:0] im;
  } complex_t;
  typedef complex_t [0:3][0:3] tile_t;
  typedef enum logic [2:0] {IDLE, READ, ISSUE, WAIT, WRITE, DONE} state_t;
endpackage

// File: rtl/fft2d_tile_addr_gen.sv
// fft2d_tile_addr_gen: tile index, wrapping source/destination addresses and last-tile detect.
module fft2d_tile_addr_gen
  import fft2d_tile_sched_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load,
  input  logic                  adv,
  input  logic [ADDR_WIDTH-1:0] src_base,
  input  logic [ADDR_WIDTH-1:0] dst_base,
  input  logic [ADDR_WIDTH:0]   num_tiles,
  output logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic [ADDR_WIDTH:0]   idx,
  output logic                  last
);
  logic [ADDR_WIDTH:0] num_q;
  // addresses track base+idx incrementally; natural overflow gives the wrap
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      rd_addr <= '0;
      wr_addr <= '0;
      idx     <= '0;
      num_q   <= '0;
    end else if (load) begin
      rd_addr <= src_base;
      wr_addr <= dst_base;
      idx     <= '0;
      num_q   <= num_tiles;
    end else if (adv) begin
      rd_addr <= rd_addr + ADDR_WIDTH'(1);
      wr_addr <= wr_addr + ADDR_WIDTH'(1);
      idx     <= idx + (ADDR_WIDTH+1)'(1);
    end
  assign last = idx == num_q - (ADDR_WIDTH+1)'(1);
endmodule

// File: rtl/fft2d_tile_sched.sv
// fft2d_tile_sched: per-tile read / FFT / write sequencer for the 4x4 2-D FFT core.
// Optional WAIT watchdog built when FFT2D_TIMEOUT_EN is defined.
module fft2d_tile_sched
  import fft2d_tile_sched_pkg::*;
#(
  parameter int ADDR_WIDTH     = DEF_ADDR_WIDTH,
  parameter int TIMEOUT_CYCLES = 1023
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] src_base,
  input  logic [ADDR_WIDTH-1:0] dst_base,
  input  logic [ADDR_WIDTH:0]   num_tiles,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic [ADDR_WIDTH:0]   tiles_done,
  output logic [ADDR_WIDTH-1:0] mem_rd_addr,
  input  tile_t                 mem_rd_data,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_wr_addr,
  output tile_t                 mem_wr_data,
  output tile_t                 fft_in,
  output logic                  fft_next,
  input  tile_t                 fft_out,
  input  logic                  fft_next_out
);
  state_t st, nxt;
  logic load, last, tmo, busy_d, done_d, next_d, we_d;
  assign load = st == IDLE && start;
  fft2d_tile_addr_gen #(.ADDR_WIDTH(ADDR_WIDTH)) u_addr (
    .clk      (clk),
    .reset    (reset),
    .load     (load),
    .adv      (st == WRITE),
    .src_base (src_base),
    .dst_base (dst_base),
    .num_tiles(num_tiles),
    .rd_addr  (mem_rd_addr),
    .wr_addr  (mem_wr_addr),
    .idx      (tiles_done),
    .last     (last)
  );
  assign fft_in = mem_rd_data;
`ifdef FFT2D_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] cnt;
  assign tmo = cnt == CW'(TIMEOUT_CYCLES - 1);
  // counter is zero outside WAIT, so it restarts on every WAIT entry
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      cnt <= '0;
      err <= 1'b0;
    end else begin
      cnt <= st == WAIT ? cnt + CW'(1) : '0;
      if (load) err <= 1'b0;
      else if (st == WAIT && !fft_next_out && tmo) err <= 1'b1;
    end
`else
  assign tmo = 1'b0;
  assign err = 1'b0;
`endif
  always_ff @(posedge clk or negedge reset)
    if (!reset) st <= IDLE;
    else st <= nxt;
  always_comb begin
    nxt = st;
    case (st)
      IDLE:    nxt = start ? (num_tiles == '0 ? DONE : READ) : IDLE;
      READ:    nxt = ISSUE;
      ISSUE:   nxt = WAIT;
      WAIT:    nxt = fft_next_out ? WRITE : (tmo ? DONE : WAIT);
      WRITE:   nxt = last ? DONE : READ;
      default: nxt = IDLE;
    endcase
  end
  // outputs are registered from the next state so they line up with it
  always_comb begin
    busy_d = nxt != IDLE;
    done_d = nxt == DONE;
    next_d = nxt == ISSUE;
    we_d   = nxt == WRITE;
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      busy        <= 1'b0;
      done        <= 1'b0;
      fft_next    <= 1'b0;
      mem_we      <= 1'b0;
      mem_wr_data <= '0;
    end else begin
      busy     <= busy_d;
      done     <= done_d;
      fft_next <= next_d;
      mem_we   <= we_d;
      if (st == WAIT && fft_next_out) mem_wr_data <= fft_out;
    end
endmodule

// File: tb/tb_fft2d_tile_sched.sv
// tb_fft2d_tile_sched: scoreboard bench with a memory model and an L=4, out=in+1 FFT model.
module tb_fft2d_tile_sched;
  import fft2d_tile_sched_pkg::*;
  localparam int AW = 13;
  localparam int NW = AW + 1;
  localparam int L  = 4;
  localparam int MSZ = 1 << AW;
  typedef struct { int addr; tile_t data; } wr_t;
  typedef struct { int lat; int tiles; int err; int nnext; int nwe; } dn_t;

  logic clk = 0, reset = 0, start = 0;
  logic [AW-1:0] src_base = '0, dst_base = '0;
  logic [NW-1:0] num_tiles = '0;
  logic busy, done, err, mem_we, fft_next, fft_next_out;
  logic [NW-1:0] tiles_done;
  logic [AW-1:0] mem_rd_addr, mem_wr_addr;
  tile_t mem_rd_data = '0, mem_wr_data, fft_in, fft_out;

  fft2d_tile_sched #(.ADDR_WIDTH(AW), .TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .reset(reset), .start(start), .src_base(src_base), .dst_base(dst_base),
    .num_tiles(num_tiles), .busy(busy), .done(done), .err(err), .tiles_done(tiles_done),
    .mem_rd_addr(mem_rd_addr), .mem_rd_data(mem_rd_data), .mem_we(mem_we),
    .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data), .fft_in(fft_in),
    .fft_next(fft_next), .fft_out(fft_out), .fft_next_out(fft_next_out)
  );

  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic tile_t pat(int a);
    tile_t t;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) begin
        t[r][c].re = 16'(a * 16 + r * 4 + c);
        t[r][c].im = 16'(a ^ 'h5a5a);
      end
    return t;
  endfunction

  function automatic tile_t inc(tile_t t);
    tile_t o = t;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) begin
        o[r][c].re = t[r][c].re + 16'sd1;
        o[r][c].im = t[r][c].im + 16'sd1;
      end
    return o;
  endfunction

  // DUT-side memory (sync read) and an independent reference image
  tile_t mem [0:MSZ-1];
  tile_t ref_mem [0:MSZ-1];
  initial for (int i = 0; i < MSZ; i++) begin mem[i] = pat(i); ref_mem[i] = pat(i); end
  always @(posedge clk) begin
    mem_rd_data <= mem[mem_rd_addr];
    if (mem_we) mem[mem_wr_addr] <= mem_wr_data;
  end

  // FFT model: answers L cycles after fft_next with in+1; can be muted or spoofed
  logic [L-1:0] v = '0;
  tile_t held = '0;
  logic spur = 0;
  int mute_from = 1 << 30, answers = 0;
  always @(posedge clk) begin
    v <= {v[L-2:0], fft_next};
    if (fft_next) held <= inc(fft_in);
    if (v[L-1] && answers < mute_from) answers <= answers + 1;
  end
  assign fft_next_out = spur | (v[L-1] && answers < mute_from);
  assign fft_out = held;

  int checks = 0, errors = 0;
  task automatic chk(string n, longint a, longint e);
    checks++;
    if (a !== e) begin errors++; $display("FAIL %s got %0d want %0d", n, a, e); end
  endtask
  task automatic chk_t(string n, tile_t a, tile_t e);
    checks++;
    if (a !== e) begin errors++; $display("FAIL %s got %0h want %0h", n, a, e); end
  endtask

  wr_t wq[$];
  dn_t dq[$];
  wr_t w;
  dn_t d;
  int st_cyc = 0, nnext = 0, nwe = 0;
  bit chk_idle = 0;
  // monitor: pops expectations whenever the DUT writes or signals done
  always @(negedge clk) if (reset) begin
    if (chk_idle) begin chk("busy_after_done", longint'(busy), 0); chk_idle = 0; end
    if (start && !busy) begin st_cyc = cyc; nnext = 0; nwe = 0; end
    if (fft_next) nnext++;
    if (mem_we) begin
      nwe++;
      if (wq.size() == 0) begin errors++; $display("FAIL unexpected_write addr %0d", mem_wr_addr); end
      else begin
        w = wq.pop_front();
        chk("wr_addr", longint'(mem_wr_addr), longint'(w.addr));
        chk_t("wr_data", mem_wr_data, w.data);
      end
    end
    if (done) begin
      if (dq.size() == 0) begin errors++; $display("FAIL unexpected_done"); end
      else begin
        d = dq.pop_front();
        chk("busy_in_done", longint'(busy), 1);
        chk("tiles_done", longint'(tiles_done), longint'(d.tiles));
        chk("err", longint'(err), longint'(d.err));
        chk("fft_next_count", longint'(nnext), longint'(d.nnext));
        chk("mem_we_count", longint'(nwe), longint'(d.nwe));
        if (d.lat >= 0) chk("done_latency", longint'(cyc - st_cyc), longint'(d.lat));
        chk_idle = 1;
      end
    end
  end

  // expected writes follow the reference image, so overlapping regions are modelled
  task automatic plan(int src, int dst, int nwr, bit with_done, int nnx, int e, int lat);
    tile_t t;
    for (int i = 0; i < nwr; i++) begin
      t = inc(ref_mem[(src + i) % MSZ]);
      ref_mem[(dst + i) % MSZ] = t;
      wq.push_back('{(dst + i) % MSZ, t});
    end
    if (with_done) dq.push_back('{lat, nwr, e, nnx, nwr});
  endtask

  task automatic kick(int src, int dst, int n);
    @(posedge clk); #1;
    src_base = AW'(src); dst_base = AW'(dst); num_tiles = NW'(n); start = 1;
    @(posedge clk); #1;
    start = 0;
  endtask

  task automatic wait_done(string n, int budget);
    for (int k = 0; k < budget; k++) begin
      @(negedge clk);
      if (done) begin repeat (3) @(negedge clk); return; end
    end
    errors++;
    $display("FAIL %s done_timeout", n);
  endtask

  task automatic chk_zero(string n);
    chk({n, "_busy"}, longint'(busy), 0);
    chk({n, "_done"}, longint'(done), 0);
    chk({n, "_err"}, longint'(err), 0);
    chk({n, "_tiles_done"}, longint'(tiles_done), 0);
    chk({n, "_mem_we"}, longint'(mem_we), 0);
    chk({n, "_fft_next"}, longint'(fft_next), 0);
    chk({n, "_rd_addr"}, longint'(mem_rd_addr), 0);
    chk({n, "_wr_addr"}, longint'(mem_wr_addr), 0);
    chk_t({n, "_wr_data"}, mem_wr_data, '0);
  endtask

  initial begin
    int seen;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_zero("reset");
    @(posedge clk); #1 reset = 1;
    repeat (2) @(posedge clk);

    // done latency is counted from the cycle start is high: N*(L+3)+1
    plan(0, 100, 3, 1, 3, 0, 3 * (L + 3) + 1);
    kick(0, 100, 3);
    wait_done("basic", 100);
    chk("tiles_done_hold", longint'(tiles_done), 3);

    plan(5, 6, 0, 1, 0, 0, 1);
    kick(5, 6, 0);
    wait_done("zero", 10);

    plan(8190, 8191, 3, 1, 3, 0, 3 * (L + 3) + 1);
    kick(8190, 8191, 3);
    wait_done("wrap", 100);

    // restarts and a stray FFT strobe while the run is in flight
    plan(30, 60, 3, 1, 3, 0, 3 * (L + 3) + 1);
    kick(30, 60, 3);
    spur = 1;
    @(posedge clk); #1 spur = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      start = ~start; src_base = AW'(500 + i); dst_base = AW'(700 + i); num_tiles = NW'(i);
    end
    start = 0;
    wait_done("restart", 100);

    // reset while waiting on tile 1 of 4
    plan(20, 40, 1, 0, 0, 0, 0);
    kick(20, 40, 4);
    seen = 0;
    for (int k = 0; k < 60 && seen < 2; k++) begin @(negedge clk); if (fft_next) seen++; end
    chk("reset_test_reached_tile1", longint'(seen), 2);
    @(posedge clk); #1 reset = 0;
    @(negedge clk);
    chk_zero("midrun");
    @(posedge clk); #1 reset = 1;
    repeat (8) @(posedge clk);
    plan(20, 40, 4, 1, 4, 0, 4 * (L + 3) + 1);
    kick(20, 40, 4);
    wait_done("after_reset", 100);

`ifdef FFT2D_TIMEOUT_EN
    mute_from = answers + 1;
    plan(200, 300, 1, 1, 2, 1, -1);
    kick(200, 300, 3);
    wait_done("timeout", 100);
    mute_from = 1 << 30;
    repeat (6) @(posedge clk);
    plan(0, 0, 0, 1, 0, 0, 1);
    kick(0, 0, 0);
    wait_done("err_clear", 10);
`endif

    repeat (4) @(posedge clk);
    chk("writes_left", longint'(wq.size()), 0);
    chk("dones_left", longint'(dq.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog");
    $fatal(1);
  end
endmodule
